// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: forwards received USB packet bytes from the receiver FIFO to the host and reports per-packet status.
module usb_rx_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       r_error,
  input  logic       empty,
  input  logic [7:0] r_data,
  input  logic [3:0] PID,
  output logic       r_enable,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       stat_valid,
  input  logic       stat_ready,
  output logic [3:0] stat_pid,
  output logic [6:0] stat_len,
  output logic [1:0] stat_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RCV, FLUSH, STATUS} state_t;
  state_t state, state_n;
  logic [6:0] len, len_n;
  logic [1:0] err, err_n;
  logic [3:0] pid_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic full, to_hit, done, pop;
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      len      <= '0;
      err      <= '0;
      tcnt     <= '0;
      stat_pid <= '0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      err      <= err_n;
      tcnt     <= tcnt_n;
      stat_pid <= pid_n;
    end
  end
  always_comb begin
    full       = len == 7'(MAX_LEN);
    done       = ~rcving & empty;
    // a full packet hides the next byte so the host never sees one that will be dropped
    rx_valid   = state == RCV && ~empty && ~full;
    pop        = rx_valid & rx_ready;
    r_enable   = ~n_rst && (pop || (state == FLUSH && ~empty));
    rx_data    = rx_valid ? r_data : '0;
    stat_valid = state == STATUS;
    tcnt_n     = (state == RCV && rcving) ? tcnt + 1'b1 : '0;
    to_hit     = state == RCV && rcving && tcnt_n == TW'(TIMEOUT);
    state_n    = state;
    len_n      = len;
    err_n      = err;
    pid_n      = stat_pid;
    case (state)
      IDLE: if (rcving || ~empty) begin
        state_n = RCV;
        len_n   = '0;
        err_n   = '0;
      end
      RCV: begin
        len_n = len + {6'b0, pop};
        if (r_error) begin
          err_n   = 2'b01;
          state_n = FLUSH;
        end else if (full && ~empty) begin
          err_n   = 2'b10;
          state_n = FLUSH;
        end else if (to_hit) begin
          err_n   = 2'b11;
          state_n = FLUSH;
        end else if (done) begin
          pid_n   = PID;
          state_n = STATUS;
        end
      end
      FLUSH: if (done) begin
        pid_n   = PID;
        state_n = STATUS;
      end
      STATUS: state_n = stat_ready ? IDLE : STATUS;
      default: state_n = IDLE;
    endcase
    stat_len = len;
    stat_err = err;
  end
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: scoreboard bench with a behavioural receiver FIFO driving usb_rx_ctrl.
module tb_usb_rx_ctrl;
  logic       tb_clk = 0;
  logic       n_rst, rcving, r_error, empty, rx_ready, stat_ready;
  logic [7:0] r_data;
  logic [3:0] PID;
  logic       r_enable, rx_valid, stat_valid;
  logic [7:0] rx_data;
  logic [3:0] stat_pid;
  logic [6:0] stat_len;
  logic [1:0] stat_err;
  int checks = 0;
  int failures = 0;
  logic [7:0]  fifo[$];
  logic [7:0]  exp_rx[$];
  logic [12:0] exp_st[$];
  logic pe;
  logic pv, pr, perr, sv, sr;
  logic [7:0] pd;
  logic [12:0] ps;

  usb_rx_ctrl #(.MAX_LEN(64), .TIMEOUT(16)) dut (
    .clk(tb_clk), .n_rst(n_rst), .rcving(rcving), .r_error(r_error), .empty(empty),
    .r_data(r_data), .PID(PID), .r_enable(r_enable), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_pid(stat_pid),
    .stat_len(stat_len), .stat_err(stat_err)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh;
    empty  = fifo.size() == 0;
    r_data = fifo.size() > 0 ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  task automatic tick;
    @(posedge tb_clk);
    #2;
  endtask

  always @(posedge tb_clk) begin
    pe = r_enable;
    #1;
    if (pe && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  end

  always @(negedge tb_clk) begin
    if (r_enable) chk("ren_empty", {31'b0, empty}, 0);
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual=%0h expected=none at %0t", rx_data, $time);
      end else chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
    end
    if (stat_valid && stat_ready) begin
      if (exp_st.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stat_unexpected actual=%0h expected=none at %0t", {stat_pid, stat_len, stat_err}, $time);
      end else chk("status", {19'b0, stat_pid, stat_len, stat_err}, {19'b0, exp_st.pop_front()});
    end
    if (!n_rst && pv && !pr && !perr) chk("rx_hold", {23'b0, rx_valid, rx_data}, {23'b0, 1'b1, pd});
    if (!n_rst && sv && !sr) chk("stat_hold", {18'b0, stat_valid, stat_pid, stat_len, stat_err}, {18'b0, 1'b1, ps});
    pv = rx_valid; pr = rx_ready; pd = rx_data; perr = r_error;
    sv = stat_valid; sr = stat_ready; ps = {stat_pid, stat_len, stat_err};
  end

  task automatic wait_done;
    int n = 0;
    while ((exp_rx.size() != 0 || exp_st.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=pending rx=%0d st=%0d expected=0", exp_rx.size(), exp_st.size());
      exp_rx.delete();
      exp_st.delete();
    end
    repeat (3) tick();
  endtask

  task automatic check_reset;
    chk("rst_r_enable", {31'b0, r_enable}, 0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 0);
    chk("rst_stat_valid", {31'b0, stat_valid}, 0);
    chk("rst_rx_data", {24'b0, rx_data}, 0);
    chk("rst_stat_pid", {28'b0, stat_pid}, 0);
    chk("rst_stat_len", {25'b0, stat_len}, 0);
    chk("rst_stat_err", {30'b0, stat_err}, 0);
  endtask

  initial begin
    n_rst = 1; rcving = 0; r_error = 0; PID = 0; rx_ready = 1; stat_ready = 1;
    pv = 0; pr = 0; perr = 0; sv = 0; sr = 0; pd = 0; ps = 0;
    refresh();
    repeat (2) tick();
    n_rst = 0;
    tick();
    check_reset();
    // single byte packet
    exp_rx.push_back(8'h55);
    exp_st.push_back({4'b0001, 7'd1, 2'b00});
    rcving = 1; PID = 4'b0001;
    tick();
    push(8'h55);
    tick();
    rcving = 0;
    wait_done();
    // host stalls mid-packet
    exp_rx.push_back(8'hFF); exp_rx.push_back(8'hF7); exp_rx.push_back(8'hCF);
    exp_st.push_back({4'b1011, 7'd3, 2'b00});
    rcving = 1; PID = 4'b1011;
    push(8'hFF);
    repeat (2) tick();
    rx_ready = 0;
    push(8'hF7); push(8'hCF);
    tick();
    rcving = 0;
    repeat (10) tick();
    rx_ready = 1;
    wait_done();
    // receiver error after one byte
    exp_rx.push_back(8'h11);
    exp_st.push_back({4'b0001, 7'd1, 2'b01});
    rcving = 1; PID = 4'b0001;
    push(8'h11);
    repeat (2) tick();
    rx_ready = 0; r_error = 1;
    push(8'h22); push(8'h33);
    tick();
    r_error = 0; rx_ready = 1; rcving = 0;
    wait_done();
    chk("fifo_after_err", fifo.size(), 0);
    // overflow: 70 bytes, 64 forwarded
    for (int i = 0; i < 64; i++) exp_rx.push_back(8'(i + 1));
    exp_st.push_back({4'b0011, 7'd64, 2'b10});
    rcving = 1; PID = 4'b0011;
    for (int i = 0; i < 70; i++) push(8'(i + 1));
    tick();
    rcving = 0;
    wait_done();
    chk("fifo_after_ovf", fifo.size(), 0);
    // zero-byte packet followed by a packet buffered while status stalls
    exp_st.push_back({4'b0001, 7'd0, 2'b00});
    exp_rx.push_back(8'h81);
    exp_st.push_back({4'b1011, 7'd1, 2'b00});
    rcving = 1; PID = 4'b0001;
    repeat (2) tick();
    rcving = 0; stat_ready = 0;
    tick();
    PID = 4'b1011; rcving = 1;
    push(8'h81);
    tick();
    rcving = 0;
    repeat (200) tick();
    chk("stall_rx_queued", exp_rx.size(), 1);
    chk("stall_st_queued", exp_st.size(), 2);
    stat_ready = 1;
    wait_done();
    // timeout then reset mid-flush
    rcving = 1; PID = 4'b0101;
    repeat (18) tick();
    chk("timeout_err", {30'b0, stat_err}, 2'b11);
    chk("timeout_no_stat", {31'b0, stat_valid}, 0);
    n_rst = 1;
    repeat (2) tick();
    n_rst = 0; rcving = 0;
    tick();
    check_reset();
    repeat (20) tick();
    chk("end_rx_queue", exp_rx.size(), 0);
    chk("end_st_queue", exp_st.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
